// File: rtl/lvds_tx_pkg.sv
// Shared types and frame constants for the LVDS transmit word-slot scheduler.
package lvds_tx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREPARE  = 2'd1,
        TRANSMIT = 2'd2
    } tx_state_e;

    localparam int          SAMPLE_BITS   = 13;
    localparam logic [31:0] FRAME_TRAILER = 32'h8000_4000;
    localparam logic [31:0] FRAME_IDLE    = 32'h0000_0000;

    // I lane carries a set start bit and a trailing 1, Q lane a 01 lead-in and trailing 0.
    function automatic logic [31:0] pack_frame(
        input logic [SAMPLE_BITS-1:0] i,
        input logic [SAMPLE_BITS-1:0] q
    );
        return {2'b10, i, 1'b1, 2'b01, q, 1'b0};
    endfunction

endpackage

// File: rtl/lvds_tx_sequencer_if.sv
// Sample request handshake between the sequencer (master) and the signal generator (slave).
interface lvds_tx_sequencer_if;
    import lvds_tx_pkg::*;

    logic                   o_gen_enable;
    logic                   i_gen_done;
    logic [SAMPLE_BITS-1:0] i_sample_i;
    logic [SAMPLE_BITS-1:0] i_sample_q;

    modport master (
        output o_gen_enable,
        input  i_gen_done,
        input  i_sample_i,
        input  i_sample_q
    );

    modport slave (
        input  o_gen_enable,
        output i_gen_done,
        output i_sample_i,
        output i_sample_q
    );

endinterface

// File: rtl/lvds_rise_det.sv
// Rising-edge detector whose history register resets to a chosen level, so a
// level already high when reset releases can be treated as "no edge".
module lvds_rise_det #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_r;

    // Previous-cycle copy of the input.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_r <= RST_VAL;
        end else begin
            d_r <= d;
        end
    end

    assign rise = d & ~d_r;

endmodule

// File: rtl/lvds_tx_sequencer.sv
// Word-slot scheduler: requests samples, packs them into LVDS frames separated by
// idle words, closes each message with a trailer and arbitrates the sample RAM port.
module lvds_tx_sequencer
    import lvds_tx_pkg::*;
#(
    parameter int SAMPLE_W = 13,
    parameter int DIV_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_transmit,
    input  logic [DIV_W-1:0]    i_prep_div,
    input  logic                i_word_done,
    lvds_tx_sequencer_if.master gen,
    output logic [31:0]         o_tx_data,
    output logic                o_ram_owner,
    output logic                o_msg_done,
    output logic [15:0]         o_frames
);

    tx_state_e           state_r;
    tx_state_e           state_s;
    logic [DIV_W-1:0]    cnt_r;
    logic [DIV_W-1:0]    cnt_s;
    logic [DIV_W-1:0]    div_r;
    logic [DIV_W-1:0]    div_s;
    logic [31:0]         tx_data_r;
    logic [31:0]         tx_data_s;
    logic [15:0]         frames_r;
    logic [15:0]         frames_s;
    logic                pending_r;
    logic                msg_r;
    logic                prep_seen_r;
    logic                gen_enable_r;
    logic                consume_s;
    logic                stb_s;
    logic                tx_rise_s;
    logic [SAMPLE_W-1:0] smp_i_s;
    logic [SAMPLE_W-1:0] smp_q_s;
    logic [31:0]         frame_s;

    lvds_rise_det #(.RST_VAL(1'b1)) u_word_det (
        .clk   (clk),
        .reset (reset),
        .d     (i_word_done),
        .rise  (stb_s)
    );

    lvds_rise_det #(.RST_VAL(1'b1)) u_tx_det (
        .clk   (clk),
        .reset (reset),
        .d     (i_transmit),
        .rise  (tx_rise_s)
    );

    assign smp_i_s = gen.i_sample_i;
    assign smp_q_s = gen.i_sample_q;
    assign frame_s = pack_frame(smp_i_s, smp_q_s);

    // Slot-synchronous next-state and datapath decode; nothing moves without a strobe.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        div_s     = div_r;
        tx_data_s = tx_data_r;
        frames_s  = frames_r;
        consume_s = 1'b0;
        if (stb_s) begin
            case (state_r)
                IDLE: begin
                    tx_data_s = FRAME_IDLE;
                    if (pending_r) begin
                        cnt_s     = {DIV_W{1'b0}};
                        div_s     = i_prep_div;
                        frames_s  = 16'd0;
                        consume_s = 1'b1;
                        state_s   = PREPARE;
                    end else begin
                        state_s   = IDLE;
                    end
                end
                PREPARE: begin
                    cnt_s = cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
                    if (cnt_r == div_r) begin
                        tx_data_s = frame_s;
                        frames_s  = frames_r + 16'd1;
                        state_s   = TRANSMIT;
                    end else begin
                        state_s   = PREPARE;
                    end
                end
                TRANSMIT: begin
                    if (msg_r) begin
                        tx_data_s = FRAME_TRAILER;
                        state_s   = IDLE;
                    end else begin
                        tx_data_s = FRAME_IDLE;
                        cnt_s     = {DIV_W{1'b0}};
                        state_s   = PREPARE;
                    end
                end
                default: begin
                    tx_data_s = FRAME_IDLE;
                    state_s   = IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // FSM state and slot datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= {DIV_W{1'b0}};
            div_r     <= {DIV_W{1'b0}};
            tx_data_r <= FRAME_IDLE;
            frames_r  <= 16'd0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            div_r     <= div_s;
            tx_data_r <= tx_data_s;
            frames_r  <= frames_s;
        end
    end

    // Request latch, end-of-message flag and sample request pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r    <= 1'b0;
            msg_r        <= 1'b0;
            prep_seen_r  <= 1'b0;
            gen_enable_r <= 1'b0;
        end else begin
            // Requests arriving while a message is in flight are dropped, not queued.
            if (consume_s) begin
                pending_r <= 1'b0;
            end else if (tx_rise_s && (state_r == IDLE)) begin
                pending_r <= 1'b1;
            end else begin
                pending_r <= pending_r;
            end

            if (state_r == IDLE) begin
                msg_r <= 1'b0;
            end else if (gen.i_gen_done) begin
                msg_r <= 1'b1;
            end else begin
                msg_r <= msg_r;
            end

            prep_seen_r  <= (state_r == PREPARE);
            gen_enable_r <= (state_r == PREPARE) && !prep_seen_r && !msg_r;
        end
    end

    assign gen.o_gen_enable = gen_enable_r;
    assign o_tx_data        = tx_data_r;
    assign o_ram_owner      = (state_r != IDLE);
    assign o_msg_done       = msg_r;
    assign o_frames         = frames_r;

endmodule

// File: tb/tb_lvds_tx_sequencer.sv
// Self-checking bench for lvds_tx_sequencer with a slot-level reference model.
module tb_lvds_tx_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_transmit;
    logic [3:0]  i_prep_div;
    logic        i_word_done;
    logic [31:0] o_tx_data;
    logic        o_ram_owner;
    logic        o_msg_done;
    logic [15:0] o_frames;

    lvds_tx_sequencer_if gen();

    lvds_tx_sequencer #(.SAMPLE_W(13), .DIV_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_transmit  (i_transmit),
        .i_prep_div  (i_prep_div),
        .i_word_done (i_word_done),
        .gen         (gen),
        .o_tx_data   (o_tx_data),
        .o_ram_owner (o_ram_owner),
        .o_msg_done  (o_msg_done),
        .o_frames    (o_frames)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passed = 0;
    int          n_en;
    int          gen_idx;
    int          gen_n;
    logic [12:0] si [8];
    logic [12:0] sq [8];
    logic [31:0] w_log [64];
    logic [31:0] w_word;
    logic        w_own;
    logic        w_msg;
    logic [15:0] w_frames;

    // One clock; also plays the generator, answering each request pulse.
    task automatic tick();
        @(posedge clk);
        #1;
        if (gen.o_gen_enable === 1'b1) begin
            n_en++;
            if (gen_idx < 8) begin
                gen.i_sample_i = si[gen_idx];
                gen.i_sample_q = sq[gen_idx];
            end
            gen_idx++;
            if (gen_idx >= gen_n) gen.i_gen_done = 1'b1;
        end
    endtask

    // One word slot: tx_done rises, outputs are captured after that edge, then 8-clock period.
    task automatic slot();
        i_word_done = 1'b1;
        tick();
        w_word   = o_tx_data;
        w_own    = o_ram_owner;
        w_msg    = o_msg_done;
        w_frames = o_frames;
        repeat (3) tick();
        i_word_done = 1'b0;
        repeat (4) tick();
    endtask

    function automatic logic [31:0] ref_frame(input int k);
        logic [31:0] w;
        w = 32'h8000_0000 + 32'h0001_0000 + 32'h0000_4000;
        w = w + ({19'd0, si[k]} << 17) + ({19'd0, sq[k]} << 1);
        return w;
    endfunction

    // Slot 0 is the strobe that accepts the request; each sample then takes div+2 slots.
    function automatic logic [31:0] ref_word(input int s, input int div, input int n);
        int per;
        int k;
        int pos;
        per = div + 2;
        if (s == 0) return 32'h0;
        k   = (s - 1) / per;
        pos = (s - 1) % per;
        if (k >= n) return 32'h0;
        if (pos == div) return ref_frame(k);
        if (pos == div + 1 && k == n - 1) return 32'h8000_4000;
        return 32'h0;
    endfunction

    function automatic int ref_frames(input int s, input int div, input int n);
        int f;
        if (s < 1 + div) return 0;
        f = (s - 1 - div) / (div + 2) + 1;
        return (f > n) ? n : f;
    endfunction

    task automatic gen_setup(input int n, input bit randomize_samples);
        gen_n = n;
        gen_idx = 0;
        n_en = 0;
        gen.i_gen_done = 1'b0;
        if (randomize_samples) begin
            for (int k = 0; k < 8; k++) begin
                si[k] = 13'($urandom);
                sq[k] = 13'($urandom);
            end
        end
    endtask

    task automatic run_msg(input int div, input int n, input int div_after,
                           input bit extra_edge, input bit randomize_samples);
        int per;
        int total;
        gen_setup(n, randomize_samples);
        per   = div + 2;
        total = n * per + 2;
        i_prep_div = 4'(div);
        i_transmit = 1'b1;
        tick();
        i_transmit = 1'b0;
        tick();
        for (int s = 0; s < total; s++) begin
            slot();
            w_log[s] = w_word;
            if (s == 0) i_prep_div = 4'(div_after);
            if (s == 1 && extra_edge) begin
                i_transmit = 1'b1;
                tick();
                i_transmit = 1'b0;
                tick();
            end
            checks++;
            if (w_word !== ref_word(s, div, n))
                $display("FAIL word s=%0d div=%0d n=%0d: got %h expected %h", s, div, n, w_word, ref_word(s, div, n));
            else passed++;
            checks++;
            if (w_own !== (s < n * per))
                $display("FAIL ram_owner s=%0d: got %b expected %b", s, w_own, (s < n * per));
            else passed++;
            checks++;
            if (w_frames !== 16'(ref_frames(s, div, n)))
                $display("FAIL frames s=%0d: got %0d expected %0d", s, w_frames, ref_frames(s, div, n));
            else passed++;
            if (s == n * per - 1) begin
                checks++;
                if (w_msg !== 1'b1) $display("FAIL msg_done_set s=%0d: got %b expected 1", s, w_msg);
                else passed++;
            end
            if (s == total - 1) begin
                checks++;
                if (w_msg !== 1'b0) $display("FAIL msg_done_clear s=%0d: got %b expected 0", s, w_msg);
                else passed++;
            end
        end
        checks++;
        if (n_en !== n) $display("FAIL gen_enable_count: got %0d expected %0d", n_en, n);
        else passed++;
        gen.i_gen_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        i_transmit = 1'b0;
        i_word_done = 1'b0;
        i_prep_div = 4'd0;
        gen_setup(0, 1'b1);
        gen.i_sample_i = 13'd0;
        gen.i_sample_q = 13'd0;
        repeat (3) tick();
        reset = 1'b0;
        checks++;
        if (o_tx_data !== 32'h0) $display("FAIL reset_tx_data: got %h expected 0", o_tx_data); else passed++;
        checks++;
        if (o_ram_owner !== 1'b0) $display("FAIL reset_owner: got %b expected 0", o_ram_owner); else passed++;
        checks++;
        if (o_msg_done !== 1'b0) $display("FAIL reset_msg_done: got %b expected 0", o_msg_done); else passed++;
        checks++;
        if (o_frames !== 16'd0) $display("FAIL reset_frames: got %0d expected 0", o_frames); else passed++;
        checks++;
        if (gen.o_gen_enable !== 1'b0) $display("FAIL reset_gen_enable: got %b expected 0", gen.o_gen_enable); else passed++;
        tick();
    endtask

    task automatic test_no_request();
        gen_setup(1, 1'b1);
        for (int s = 0; s < 4; s++) begin
            slot();
            checks++;
            if (w_word !== 32'h0 || w_own !== 1'b0)
                $display("FAIL no_request s=%0d: got word %h owner %b expected 0/0", s, w_word, w_own);
            else passed++;
        end
        checks++;
        if (n_en !== 0) $display("FAIL no_request_gen_enable: got %0d expected 0", n_en); else passed++;
    endtask

    task automatic test_single();
        si[0] = 13'h0001;
        sq[0] = 13'h0002;
        run_msg(3, 1, 3, 1'b0, 1'b0);
        checks++;
        if (w_log[4] !== 32'h8003_4004) $display("FAIL single_frame: got %h expected 80034004", w_log[4]);
        else passed++;
        checks++;
        if (w_log[5] !== 32'h8000_4000) $display("FAIL single_trailer: got %h expected 80004000", w_log[5]);
        else passed++;
    endtask

    task automatic test_three();
        run_msg(0, 3, 0, 1'b0, 1'b1);
    endtask

    task automatic test_hold_through_reset();
        reset = 1'b1;
        i_transmit = 1'b1;
        i_word_done = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (o_ram_owner !== 1'b0 || o_tx_data !== 32'h0)
            $display("FAIL held_level_strobe: got owner %b word %h expected 0/0", o_ram_owner, o_tx_data);
        else passed++;
        i_word_done = 1'b0;
        repeat (4) tick();
        gen_setup(1, 1'b1);
        for (int s = 0; s < 3; s++) begin
            slot();
            checks++;
            if (w_own !== 1'b0 || w_word !== 32'h0)
                $display("FAIL held_transmit s=%0d: got owner %b word %h expected 0/0", s, w_own, w_word);
            else passed++;
        end
        i_transmit = 1'b0;
        tick();
        run_msg(1, 1, 1, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        gen_setup(2, 1'b1);
        i_prep_div = 4'd3;
        i_transmit = 1'b1;
        tick();
        i_transmit = 1'b0;
        tick();
        for (int s = 0; s < 5; s++) slot();
        checks++;
        if (w_word !== ref_frame(0)) $display("FAIL mid_frame: got %h expected %h", w_word, ref_frame(0));
        else passed++;
        gen.i_gen_done = 1'b1;
        tick();
        tick();
        checks++;
        if (o_msg_done !== 1'b1) $display("FAIL mid_msg_set: got %b expected 1", o_msg_done); else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (o_tx_data !== 32'h0 || o_msg_done !== 1'b0 || o_ram_owner !== 1'b0)
            $display("FAIL mid_reset: got word %h msg %b owner %b expected 0/0/0", o_tx_data, o_msg_done, o_ram_owner);
        else passed++;
        gen.i_gen_done = 1'b0;
        repeat (2) tick();
        for (int s = 0; s < 3; s++) begin
            slot();
            checks++;
            if (w_word !== 32'h0 || w_own !== 1'b0)
                $display("FAIL mid_no_trailer s=%0d: got word %h owner %b expected 0/0", s, w_word, w_own);
            else passed++;
        end
    endtask

    task automatic test_div_change();
        run_msg(3, 2, 1, 1'b0, 1'b1);
        run_msg(1, 2, 1, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int m = 0; m < 6; m++) begin
            run_msg(int'($urandom_range(0, 4)), int'($urandom_range(1, 4)),
                    int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_no_request();
        test_single();
        test_three();
        test_hold_through_reset();
        test_reset_mid();
        test_div_change();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/lvds_tx_sequencer.md
# lvds_tx_sequencer

Word-slot scheduler for the LVDS transmit path. It receives a transmit request from `control` and requests one I/Q sample at a time from `signal_gen`. It packs each sample into the 32-bit LVDS frame word, fills the gaps with idle words, and ends each message with a trailer word. Every state change happens on a `lvds_trx` word-slot boundary. It also decides whether the SPI host or the generator owns the sample RAM read port.

## Interface
Parameters:
- `SAMPLE_W`, 13: width of the I and Q samples; the frame format is fixed for 13.
- `DIV_W`, 4: width of the prepare-slot divider.

Ports:
- `clk`  in  1  system clock (`lvds_trx` slowclk domain). Single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_transmit`  in  1  level from `control`; a rising edge requests one message.
- `i_prep_div`  in  `DIV_W`  number of extra idle slots per sample. Latched at message start.
- `i_word_done`  in  1  `tx_done` level from `lvds_trx`; its rising edge is the word-slot strobe.
- `i_gen_done`  in  1  generator end-of-message flag.
- `i_sample_i`  in  13  I sample from the generator.
- `i_sample_q`  in  13  Q sample from the generator.
- `o_gen_enable`  out  1  one-cycle pulse requesting the next sample.
- `o_tx_data`  out  32  word presented to `lvds_trx`.
- `o_ram_owner`  out  1  RAM port owner: 0 = SPI host, 1 = generator.
- `o_msg_done`  out  1  sticky message-complete flag, sent to `control`.
- `o_frames`  out  16  number of sample frames sent in the current message.

## Operation
- Strobe: `stb = i_word_done & ~wd_q`.
  - `wd_q` resets to 1, so a level held high through reset gives no strobe.
- Request:
  - A rising edge of `i_transmit` (edge register resets to 1) sets `pending`.
  - `pending` is cleared when it is consumed.
  - Edges during a message are ignored and dropped.
- `msg_q` (drives `o_msg_done`):
  - Cleared while in IDLE.
  - Set when `i_gen_done` = 1 and state ≠ IDLE.
  - Otherwise holds.
- States (IDLE, PREPARE, TRANSMIT). Updates occur only on `stb`:
  - IDLE:
    - `o_tx_data` ← 0.
    - If `pending`: `cnt` ← 0, `div` ← `i_prep_div`, `o_frames` ← 0, go to PREPARE.
  - PREPARE:
    - `cnt` ← `cnt` + 1.
    - If `cnt` == `div`: `o_tx_data` ← FRAME, `o_frames` ← `o_frames` + 1 (wraps at 16 bits), go to TRANSMIT.
  - TRANSMIT:
    - If `msg_q`: `o_tx_data` ← TRAILER, go to IDLE.
    - Else: `o_tx_data` ← 0, `cnt` ← 0, go to PREPARE.
- FRAME = {2'b10, I[12:0], 1'b1, 2'b01, Q[12:0], 1'b0}.
- TRAILER = 32'h8000_4000.
- `o_gen_enable` pulses for one cycle, one clock after the first cycle in which state is PREPARE, and only if `msg_q` = 0.
- `o_ram_owner` = (state ≠ IDLE), decoded directly from the state register.
- Simultaneous `i_gen_done` and `stb` in TRANSMIT: `msg_q` is not yet set on that edge, so one more sample cycle runs.
- Reset mid-message: the next cycle shows all reset values. No trailer is sent.

## Timing
- Reset values:
  - state IDLE
  - `o_tx_data` 0
  - `o_gen_enable` 0
  - `o_ram_owner` 0
  - `o_msg_done` 0
  - `o_frames` 0
  - `cnt` 0, `div` 0, `pending` 0
- Registered outputs update on the `clk` edge one cycle after `i_word_done` rises.
- Sample period is `div` + 2 word slots. FRAME occupies exactly one slot; all other slots are 0.
- `i_sample_i`/`i_sample_q` must be stable on the `stb` edge where `cnt` == `div`.
- Generator latency budget: `div` word slots minus 2 clocks after `o_gen_enable`.
- `o_ram_owner` falls on the same edge that loads TRAILER.

## Structure
- Package `lvds_tx_pkg` holds:
  - the state enum (IDLE=0, PREPARE=1, TRANSMIT=2)
  - constants `FRAME_TRAILER` and `FRAME_IDLE`
  - function `pack_frame(i, q)`
- Sub-module `lvds_rise_det` (resettable rising-edge detector with a reset-value parameter) is instantiated twice: for `i_word_done` and for `i_transmit`.

## Test plan
- No request (reset, `i_word_done` toggling every 8 clocks, no transmit): `o_tx_data` stays 0, `o_ram_owner` 0, `o_gen_enable` never asserts.
- Single sample (`i_prep_div`=3, one transmit edge, generator returns I=13'h0001, Q=13'h0002 with `i_gen_done`=1): words after strobes 1–7 are 0, 0, 0, 0, 0x8003_4004, 0x8000_4000, 0. Exactly one `o_gen_enable`, `o_frames`=1, `o_ram_owner` high from strobe 1 to strobe 6.
- Three samples (`i_prep_div`=0): FRAME on every second slot, three `o_gen_enable` pulses, `o_frames`=3, then TRAILER, then IDLE.
- `i_transmit` held high across reset release: no message starts. A later 0→1 edge starts a message on the next strobe.
- Reset asserted for one cycle while in TRANSMIT: next cycle state IDLE, `o_tx_data`=0, `o_msg_done`=0, no trailer sent.
- `i_prep_div` changed from 3 to 1 mid-message: the current message keeps a 5-slot period; the next message uses a 3-slot period.
